// File: rtl/rv32_ctrl_pkg.sv
// Shared types and constants for the multicycle RV32I control sequencer.
package rv32_ctrl_pkg;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [1:0] {
    PC_PLUS4 = 2'd0,
    PC_IMM   = 2'd1,
    PC_ALU   = 2'd2
  } pc_sel_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_IMEM_TO = 2'd2,
    CAUSE_DMEM_TO = 2'd3
  } trap_cause_t;

  // Instruction class derived from the opcode; FENCE executes as a NOP.
  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OPIMM   = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_ILLEGAL = 4'd10
  } op_class_t;

  // Map a major opcode to its class; anything unsupported (SYSTEM included) is illegal.
  function automatic op_class_t classify_opcode(input logic [6:0] opc);
    op_class_t cls;
    case (opc)
      OPC_LUI:    cls = CLS_LUI;
      OPC_AUIPC:  cls = CLS_AUIPC;
      OPC_JAL:    cls = CLS_JAL;
      OPC_JALR:   cls = CLS_JALR;
      OPC_BRANCH: cls = CLS_BRANCH;
      OPC_LOAD:   cls = CLS_LOAD;
      OPC_STORE:  cls = CLS_STORE;
      OPC_OPIMM:  cls = CLS_OPIMM;
      OPC_OP:     cls = CLS_OP;
      OPC_FENCE:  cls = CLS_FENCE;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

  // Integer ALU operation from func3; alt selects SUB/SRA where the caller allows it.
  function automatic alu_op_t arith_op(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALU operation / operand-B select decode from opcode and function bits.
module alu_op_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] OPCODE,
  input  logic [2:0] func3,
  input  logic       func1,
  output logic [3:0] alu_op,
  output logic       alu_src_b
);

  op_class_t cls_s;
  alu_op_t   op_s;
  logic      src_b_s;

  assign cls_s = classify_opcode(OPCODE);

  // Select the ALU operation and operand-B source for the current instruction class.
  always_comb begin
    op_s    = ALU_ADD;
    src_b_s = 1'b1;
    case (cls_s)
      CLS_LUI: begin
        op_s = ALU_PASSB;
      end
      CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_STORE, CLS_FENCE: begin
        op_s = ALU_ADD;
      end
      CLS_OPIMM: begin
        // bit30 only distinguishes SRAI from SRLI; ADDI ignores it
        op_s = arith_op(func3, func1 & (func3 == 3'b101));
      end
      CLS_OP: begin
        op_s    = arith_op(func3, func1);
        src_b_s = 1'b0;
      end
      CLS_BRANCH: begin
        src_b_s = 1'b0;
        if (func3[2:1] == 2'b11) begin
          op_s = ALU_SLTU;
        end else if (func3[2:1] == 2'b10) begin
          op_s = ALU_SLT;
        end else begin
          op_s = ALU_SUB;
        end
      end
      default: begin
        op_s    = ALU_ADD;
        src_b_s = 1'b0;
      end
    endcase
  end

  assign alu_op    = op_s;
  assign alu_src_b = src_b_s;

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with bus timeouts,
// retired-instruction counter and a sticky TRAP state.
module multicycle_ctrl_fsm
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           OPCODE,
  input  logic [2:0]           func3,
  input  logic                 func1,
  input  logic                 branch_taken,
  output logic                 imem_req,
  input  logic                 imem_ready,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  output logic                 ir_load,
  output logic                 rf_we,
  output logic                 pc_load,
  output logic [1:0]           pc_sel,
  output logic [3:0]           alu_op,
  output logic                 alu_src_b,
  output logic                 retire,
  output logic [INSTRET_W-1:0] instret,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  localparam int unsigned TO_W = (MEM_TIMEOUT < 32'd2) ? 1 : $clog2(MEM_TIMEOUT + 32'd1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
  localparam logic TO_EN = (MEM_TIMEOUT != 32'd0);

  state_t         state_r, next_state_s;
  op_class_t      cls_r, dec_cls_s;
  logic [3:0]     alu_op_r, dec_alu_op_s, alu_op_s;
  logic           alu_src_b_r, dec_src_b_s, alu_src_b_s;
  logic [TO_W-1:0] to_cnt_r;
  trap_cause_t    trap_cause_r, cause_nxt_s;
  logic [INSTRET_W-1:0] instret_r;

  logic    to_hit_s, cnt_clr_s, cnt_inc_s, cause_set_s, latch_dec_s;
  logic    imem_req_s, ir_load_s, dmem_req_s, dmem_we_s;
  logic    rf_we_s, pc_load_s, retire_s;
  pc_sel_t pc_sel_s;

  alu_op_decode u_alu_op_decode (
    .OPCODE    (OPCODE),
    .func3     (func3),
    .func1     (func1),
    .alu_op    (dec_alu_op_s),
    .alu_src_b (dec_src_b_s)
  );

  assign dec_cls_s = classify_opcode(OPCODE);
  assign to_hit_s  = TO_EN && (to_cnt_r == TO_LIMIT);

  // Next-state and strobe decode; reset forces every strobe low so an aborted instruction has no effect.
  always_comb begin
    next_state_s = state_r;
    imem_req_s   = 1'b0;
    ir_load_s    = 1'b0;
    dmem_req_s   = 1'b0;
    dmem_we_s    = 1'b0;
    rf_we_s      = 1'b0;
    pc_load_s    = 1'b0;
    pc_sel_s     = PC_PLUS4;
    retire_s     = 1'b0;
    alu_op_s     = 4'd0;
    alu_src_b_s  = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    cause_set_s  = 1'b0;
    cause_nxt_s  = CAUSE_NONE;
    latch_dec_s  = 1'b0;
    if (reset) begin
      next_state_s = FETCH;
    end else begin
      case (state_r)
        FETCH: begin
          imem_req_s = 1'b1;
          // ready on the limit cycle still wins over the timeout
          if (imem_ready) begin
            ir_load_s    = 1'b1;
            next_state_s = DECODE;
          end else if (to_hit_s) begin
            next_state_s = TRAP;
            cause_set_s  = 1'b1;
            cause_nxt_s  = CAUSE_IMEM_TO;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
        DECODE: begin
          alu_op_s    = dec_alu_op_s;
          alu_src_b_s = dec_src_b_s;
          latch_dec_s = 1'b1;
          if (dec_cls_s == CLS_ILLEGAL) begin
            next_state_s = TRAP;
            cause_set_s  = 1'b1;
            cause_nxt_s  = CAUSE_ILLEGAL;
          end else begin
            next_state_s = EXEC;
          end
        end
        EXEC: begin
          alu_op_s    = alu_op_r;
          alu_src_b_s = alu_src_b_r;
          case (cls_r)
            CLS_BRANCH: begin
              pc_load_s    = 1'b1;
              pc_sel_s     = branch_taken ? PC_IMM : PC_PLUS4;
              retire_s     = 1'b1;
              next_state_s = FETCH;
            end
            CLS_LOAD, CLS_STORE: begin
              next_state_s = MEM;
            end
            default: begin
              next_state_s = WB;
            end
          endcase
        end
        MEM: begin
          alu_op_s    = alu_op_r;
          alu_src_b_s = alu_src_b_r;
          dmem_req_s  = 1'b1;
          dmem_we_s   = (cls_r == CLS_STORE);
          if (dmem_ready) begin
            if (cls_r == CLS_STORE) begin
              pc_load_s    = 1'b1;
              pc_sel_s     = PC_PLUS4;
              retire_s     = 1'b1;
              next_state_s = FETCH;
            end else begin
              next_state_s = WB;
            end
          end else if (to_hit_s) begin
            next_state_s = TRAP;
            cause_set_s  = 1'b1;
            cause_nxt_s  = CAUSE_DMEM_TO;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
        WB: begin
          alu_op_s     = alu_op_r;
          alu_src_b_s  = alu_src_b_r;
          rf_we_s      = (cls_r != CLS_FENCE);
          pc_load_s    = 1'b1;
          retire_s     = 1'b1;
          next_state_s = FETCH;
          if (cls_r == CLS_JAL) begin
            pc_sel_s = PC_IMM;
          end else if (cls_r == CLS_JALR) begin
            pc_sel_s = PC_ALU;
          end else begin
            pc_sel_s = PC_PLUS4;
          end
        end
        TRAP: begin
          next_state_s = TRAP;
        end
        default: begin
          next_state_s = FETCH;
        end
      endcase
      // any state change restarts the wait counter, which covers entry to FETCH and MEM
      cnt_clr_s = (next_state_s != state_r);
    end
  end

  // State, wait counter, trap cause, decoded-control hold and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= FETCH;
      to_cnt_r     <= {TO_W{1'b0}};
      trap_cause_r <= CAUSE_NONE;
      instret_r    <= {INSTRET_W{1'b0}};
      cls_r        <= CLS_FENCE;
      alu_op_r     <= 4'd0;
      alu_src_b_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (cnt_clr_s) begin
        to_cnt_r <= {TO_W{1'b0}};
      end else if (cnt_inc_s) begin
        to_cnt_r <= to_cnt_r + TO_W'(1'b1);
      end else begin
        to_cnt_r <= to_cnt_r;
      end
      if (cause_set_s) begin
        trap_cause_r <= cause_nxt_s;
      end else begin
        trap_cause_r <= trap_cause_r;
      end
      if (retire_s) begin
        instret_r <= instret_r + INSTRET_W'(1'b1);
      end else begin
        instret_r <= instret_r;
      end
      if (latch_dec_s) begin
        cls_r       <= dec_cls_s;
        alu_op_r    <= dec_alu_op_s;
        alu_src_b_r <= dec_src_b_s;
      end else begin
        cls_r       <= cls_r;
        alu_op_r    <= alu_op_r;
        alu_src_b_r <= alu_src_b_r;
      end
    end
  end

  assign imem_req   = imem_req_s;
  assign ir_load    = ir_load_s;
  assign dmem_req   = dmem_req_s;
  assign dmem_we    = dmem_we_s;
  assign rf_we      = rf_we_s;
  assign pc_load    = pc_load_s;
  assign pc_sel     = pc_sel_s;
  assign retire     = retire_s;
  assign alu_op     = alu_op_s;
  assign alu_src_b  = alu_src_b_s;
  assign instret    = instret_r;
  assign trap       = !reset && (state_r == TRAP);
  assign trap_cause = reset ? 2'd0 : trap_cause_r;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm with an expected-result scoreboard per instruction.
module tb_multicycle_ctrl_fsm;

  logic       clk;
  logic       reset;
  logic [6:0] OPCODE;
  logic [2:0] func3;
  logic       func1;
  logic       branch_taken;
  logic       imem_req, imem_ready;
  logic       dmem_req, dmem_we, dmem_ready;
  logic       ir_load, rf_we, pc_load, alu_src_b, retire, trap;
  logic [1:0] pc_sel, trap_cause;
  logic [3:0] alu_op;
  logic [2:0] instret;

  multicycle_ctrl_fsm #(.MEM_TIMEOUT(4), .INSTRET_W(3)) dut (
    .clk(clk), .reset(reset), .OPCODE(OPCODE), .func3(func3), .func1(func1),
    .branch_taken(branch_taken), .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .ir_load(ir_load), .rf_we(rf_we), .pc_load(pc_load), .pc_sel(pc_sel),
    .alu_op(alu_op), .alu_src_b(alu_src_b), .retire(retire), .instret(instret),
    .trap(trap), .trap_cause(trap_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    int         rfwe;
    int         ret_cyc;
    int         memcyc;
    logic [2:0] instret;
  } exp_t;

  exp_t       sb[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [2:0] model_instret = 3'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected ALU controls, PC select, RF writes and latency per instruction word.
  function automatic void model(input logic [31:0] ins, input logic taken,
                                output logic [3:0] a, output logic sb_, output logic [1:0] sel,
                                output int rf, output int base, output bit ismem, output bit we);
    int tbl [8];
    logic [2:0] f3;
    tbl = '{0, 2, 3, 4, 5, 6, 8, 9};
    f3 = ins[14:12];
    a = 4'd0; sb_ = 1'b1; sel = 2'd0; rf = 1; base = 4; ismem = 0; we = 0;
    case (ins[6:0])
      7'h37: a = 4'd10;
      7'h17: a = 4'd0;
      7'h6F: sel = 2'd1;
      7'h67: sel = 2'd2;
      7'h63: begin
        sb_ = 1'b0; rf = 0; base = 3; sel = taken ? 2'd1 : 2'd0;
        a = (f3 == 3'd6 || f3 == 3'd7) ? 4'd4 : (f3 == 3'd4 || f3 == 3'd5) ? 4'd3 : 4'd1;
      end
      7'h03: begin base = 5; ismem = 1; end
      7'h23: begin rf = 0; ismem = 1; we = 1; end
      7'h13: begin
        a = 4'(tbl[f3]);
        if (f3 == 3'd5 && ins[30]) a = 4'd7;
      end
      7'h33: begin
        sb_ = 1'b0;
        a = 4'(tbl[f3]);
        if (f3 == 3'd5 && ins[30]) a = 4'd7;
        if (f3 == 3'd0 && ins[30]) a = 4'd1;
      end
      7'h0F: rf = 0;
      default: a = 4'd0;
    endcase
  endfunction

  // Runs one instruction: fd = fetch wait cycles, dw = data wait cycles.
  task automatic run_instr(input string nm, input logic [31:0] ins, input logic taken,
                           input int fd, input int dw);
    exp_t e, got;
    logic [3:0] a; logic sb_; logic [1:0] sel; int rf, base; bit ismem, we;
    int mem_cyc, rf_cnt; bit done;
    model(ins, taken, a, sb_, sel, rf, base, ismem, we);
    model_instret = model_instret + 3'd1;
    e.sel = sel; e.rfwe = rf; e.instret = model_instret;
    e.ret_cyc = fd + base - 1 + (ismem ? dw : 0);
    e.memcyc  = ismem ? dw + 1 : 0;
    sb.push_back(e);
    mem_cyc = 0; rf_cnt = 0; done = 0;
    OPCODE = ins[6:0]; func3 = ins[14:12]; func1 = ins[30]; branch_taken = taken;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      imem_ready = (cyc == fd);
      dmem_ready = ismem && (cyc == fd + 3 + dw);
      #1;
      if (cyc <= fd) begin
        chk({nm, "_imem_req"}, imem_req, 1);
        chk({nm, "_ir_load"}, ir_load, (cyc == fd));
      end else begin
        chk({nm, "_alu_op"}, alu_op, a);
        chk({nm, "_alu_src_b"}, alu_src_b, sb_);
      end
      if (dmem_req) begin
        mem_cyc++;
        chk({nm, "_dmem_we"}, dmem_we, we);
      end else begin
        chk({nm, "_dmem_we_idle"}, dmem_we, 0);
      end
      if (rf_we) rf_cnt++;
      if (retire) begin
        got = sb.pop_front();
        chk({nm, "_pc_load"}, pc_load, 1);
        chk({nm, "_pc_sel"}, pc_sel, got.sel);
        chk({nm, "_retire_cycle"}, cyc, got.ret_cyc);
        chk({nm, "_rf_we_count"}, rf_cnt, got.rfwe);
        chk({nm, "_dmem_req_cycles"}, mem_cyc, got.memcyc);
        done = 1;
      end
      @(negedge clk);
    end
    chk({nm, "_retired"}, done, 1);
    if (done) chk({nm, "_instret"}, instret, got.instret);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
  endtask

  // Asserts reset at the next falling edge, checks strobes are suppressed and state clears.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    #1;
    chk("rst_retire", retire, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc_load", pc_load, 0);
    chk("rst_ir_load", ir_load, 0);
    @(posedge clk); #1;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_trap", trap, 0);
    chk("rst_trap_cause", trap_cause, 0);
    chk("rst_instret", instret, 0);
    chk("rst_alu_op", alu_op, 0);
    @(negedge clk);
    reset = 1'b0; model_instret = 3'd0;
    #1;
    chk("post_rst_imem_req", imem_req, 1);
  endtask

  initial begin
    reset = 1'b1; OPCODE = 7'd0; func3 = 3'd0; func1 = 1'b0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    do_reset();

    run_instr("add",   32'h002081B3, 1'b0, 0, 0);
    run_instr("sub",   32'h402081B3, 1'b0, 0, 0);
    run_instr("srai",  32'h4050D193, 1'b0, 0, 0);
    run_instr("addi",  32'h40008093, 1'b0, 0, 0);
    run_instr("lw",    32'h0000A183, 1'b0, 0, 3);
    run_instr("sw",    32'h0020A023, 1'b0, 0, 0);
    run_instr("beq_t", 32'h00208463, 1'b1, 0, 0);
    run_instr("beq_n", 32'h00208463, 1'b0, 0, 0);
    run_instr("bltu",  32'h0020E463, 1'b1, 0, 0);
    run_instr("blt",   32'h0020C463, 1'b0, 0, 0);
    run_instr("xor",   32'h0020C1B3, 1'b0, 0, 0);
    run_instr("lui",   32'h000010B7, 1'b0, 0, 0);
    run_instr("auipc", 32'h00000097, 1'b0, 0, 0);
    run_instr("jal",   32'h008000EF, 1'b0, 0, 0);
    run_instr("jalr",  32'h000080E7, 1'b0, 0, 0);
    run_instr("fence", 32'h0000000F, 1'b0, 0, 0);
    run_instr("add_fetch_limit", 32'h002081B3, 1'b0, 4, 0);
    run_instr("sw_mem_limit",    32'h0020A023, 1'b0, 0, 4);

    // illegal opcode (ECALL) parks in TRAP with cause 1
    OPCODE = 7'h73; func3 = 3'd0; func1 = 1'b0;
    imem_ready = 1'b1;
    #1 chk("ecall_ir_load", ir_load, 1);
    @(negedge clk); imem_ready = 1'b0;
    #1 chk("ecall_decode_retire", retire, 0);
    chk("ecall_decode_trap", trap, 0);
    @(negedge clk); #1;
    chk("ecall_trap", trap, 1);
    chk("ecall_cause", trap_cause, 1);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1'b1;
      #1;
      chk("ecall_no_imem_req", imem_req, 0);
      chk("ecall_no_ir_load", ir_load, 0);
      chk("ecall_trap_held", trap, 1);
      chk("ecall_cause_held", trap_cause, 1);
      @(negedge clk);
    end
    do_reset();

    // fetch timeout: no imem_ready for the whole window
    for (int c = 0; c < 5; c++) begin
      chk("imem_to_req", imem_req, 1);
      chk("imem_to_trap_early", trap, 0);
      @(negedge clk); #1;
    end
    chk("imem_to_trap", trap, 1);
    chk("imem_to_cause", trap_cause, 2);
    chk("imem_to_req_off", imem_req, 0);
    do_reset();

    // data timeout on a load
    OPCODE = 7'h03; func3 = 3'd2; func1 = 1'b0;
    imem_ready = 1'b1;
    #1 chk("dmem_to_ir_load", ir_load, 1);
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk); #1;
    chk("dmem_to_exec_req", dmem_req, 0);
    @(negedge clk); #1;
    for (int c = 3; c < 8; c++) begin
      chk("dmem_to_req", dmem_req, 1);
      chk("dmem_to_we", dmem_we, 0);
      chk("dmem_to_trap_early", trap, 0);
      @(negedge clk); #1;
    end
    chk("dmem_to_trap", trap, 1);
    chk("dmem_to_cause", trap_cause, 3);
    chk("dmem_to_req_off", dmem_req, 0);
    chk("dmem_to_we_off", dmem_we, 0);
    do_reset();

    // reset landing in WB of an ADD must suppress its strobes
    OPCODE = 7'h33; func3 = 3'd0; func1 = 1'b0;
    imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0;
    @(negedge clk);
    do_reset();
    run_instr("add_after_abort", 32'h002081B3, 1'b0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multicycle RV32I control sequencer that drives the instruction decoder and the shared datapath (PC, IR, register file, ALU, memory port). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB using OPCODE, func3 and func1 from the decoder. It handshakes with instruction and data memories, counts retired instructions, and parks in a sticky TRAP state on an illegal opcode or a bus timeout.

Parameters:
MEM_TIMEOUT, 255, max cycles a memory request may wait for ready; 0 disables the timeout.
INSTRET_W, 32, width of the retired-instruction counter.

Ports:
clk  input  1  single clock, all state on rising edge
reset  input  1  synchronous, active-high
OPCODE  input  7  decoded instruction[6:0], valid from DECODE onward
func3  input  3  decoded instruction[14:12]
func1  input  1  decoded instruction[30]
branch_taken  input  1  comparator result, sampled in EXEC
imem_req  output  1  instruction fetch request
imem_ready  input  1  fetch data valid this cycle
dmem_req  output  1  data access request
dmem_we  output  1  1 = store, 0 = load; valid while dmem_req=1
dmem_ready  input  1  data access complete this cycle
ir_load  output  1  latch fetched word into IR
rf_we  output  1  register-file write strobe
pc_load  output  1  update PC
pc_sel  output  2  0 = PC+4, 1 = PC+imm (branch/JAL), 2 = ALU result (JALR)
alu_op  output  4  ALU operation code
alu_src_b  output  1  0 = rs2, 1 = immediate
retire  output  1  one-cycle pulse per completed instruction
instret  output  INSTRET_W  retired-instruction count, wraps
trap  output  1  sticky error flag
trap_cause  output  2  0 = none, 1 = illegal opcode, 2 = imem timeout, 3 = dmem timeout

Behaviour:
- Reset: state=FETCH. All outputs 0 (trap_cause=0, instret=0). imem_req rises the first cycle after reset deasserts. Reset mid-instruction aborts with no strobes.
- FETCH: imem_req=1. On imem_ready: ir_load=1 the same cycle, go to DECODE. Wait cycles hold imem_req.
- DECODE: one cycle. Classify OPCODE as LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011, FENCE 0001111 (NOP). Any other value, including SYSTEM 1110011, goes to TRAP with cause 1. Otherwise go to EXEC.
- EXEC, one cycle:
  - BRANCH: pc_load=1, pc_sel = branch_taken ? 1 : 0, retire, go to FETCH.
  - LOAD/STORE: alu_op=ADD, alu_src_b=1, go to MEM.
  - All others: go to WB.
- MEM: dmem_req=1, dmem_we=(STORE), both held until dmem_ready.
  - On ready, STORE: pc_load=1, pc_sel=0, retire, go to FETCH.
  - On ready, LOAD: go to WB.
- WB, one cycle: rf_we=1 (FENCE: rf_we=0), pc_load=1, pc_sel = JAL ? 1 : JALR ? 2 : 0, retire, go to FETCH.
- Instruction latencies, excluding memory waits: branch 3 cycles, ALU/jump/upper 4, store 4, load 5.
- alu_op encoding: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
- alu_op decode:
  - OP: func3 selects the operation; func1 picks SUB for func3=000 and SRA for func3=101.
  - OP-IMM: func1 is honoured only for func3=101 (SRAI); ADDI is always ADD.
  - alu_src_b=1 for every type except OP and BRANCH.
  - LUI=PASSB. AUIPC, JAL, JALR=ADD.
  - BRANCH: SUB, except func3 110/111 use SLTU and 100/101 use SLT.
- alu_op and alu_src_b are held stable from DECODE through WB.
- Timeout: a counter clears on entry to FETCH or MEM and increments each wait cycle. If the count reaches MEM_TIMEOUT without ready, go to TRAP with cause 2 (FETCH) or 3 (MEM). A ready arriving on the same cycle as the limit wins, and the instruction completes.
- TRAP: all strobes 0, trap=1, trap_cause held. Only reset exits TRAP.
- retire pulses exactly in the cycle pc_load=1. instret increments on retire and wraps from all-ones to 0.
- Strobes (ir_load, rf_we, pc_load, retire) are single-cycle. dmem_we is 0 whenever dmem_req=0.

Decomposition:
- Shared package rv32_ctrl_pkg holds: opcode constants; state_t enum {FETCH, DECODE, EXEC, MEM, WB, TRAP}; alu_op_t enum; pc_sel_t enum; trap_cause_t enum.
- Sub-module alu_op_decode: purely combinational (OPCODE, func3, func1 → alu_op, alu_src_b).
- The FSM, timeout counter and instret counter stay in the top module.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), imem_ready on first request → ir_load at cycle 0, alu_op=0, alu_src_b=0, rf_we+pc_load(sel 0)+retire at cycle 3, instret=1.
- SUB (0x402081B3) then SRAI (0x4050D193) → alu_op=1 then 7. ADDI with bit30=1 (0x40008093) → alu_op=0.
- LW (0x0000A183) with dmem_ready delayed 3 cycles → dmem_req=1, dmem_we=0 held 4 cycles, rf_we 1 cycle after ready. SW (0x0020A023) → dmem_we=1, no rf_we.
- BEQ (0x00208463): branch_taken=1 → pc_sel=1 at cycle 2. branch_taken=0 → pc_sel=0. rf_we never asserts.
- Opcode 0x73 (ECALL) → trap=1, cause=1 after DECODE. No further imem_req until reset, then FETCH resumes with instret=0.
- MEM_TIMEOUT=4, imem_ready held 0 → trap cause 2 after 4 wait cycles. Repeat with ready on cycle 4 → instruction completes, no trap.
